// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared constants for the 7-segment scan driver: hex-to-segment
//             table (active-low gfedcba), blank pattern, digit-enable helpers.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Largest number of digits the driver supports.
  localparam int MAX_DIGITS = 8;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All digit enables off (enables are active-low); slice to the digit count.
  localparam logic [MAX_DIGITS-1:0] EN_ALL_OFF = '1;

  // Hex digit 0..F to active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Table lookup for one nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver_if
//  Brief    : Load port and display pins of the 7-segment scan driver.
//             master = the debug-tap side that loads words,
//             slave  = the scan driver itself.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    load;
  logic [6:0]              out7;
  logic [NUM_DIGITS-1:0]   en_out;
  logic                    frame_done;
  logic                    update_ack;

  modport master (
    output data_in,
    output load,
    input  out7,
    input  en_out,
    input  frame_done,
    input  update_ack
  );

  modport slave (
    input  data_in,
    input  load,
    output out7,
    output en_out,
    output frame_done,
    output update_ack
  );

endinterface
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Brief    : Combinational nibble to active-low 7-segment pattern decoder.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup; the output register sits in the top level.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Brief    : Time-multiplexed hex display driver. Scans NUM_DIGITS digits,
//             one REFRESH_DIV-clock slot each (first clock of a slot blanked
//             against ghosting). New words are applied only at frame wrap so
//             the display never tears. Optional leading-zero suppression.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         c_p_last = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]         c_d_last = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_en_off = EN_ALL_OFF[NUM_DIGITS-1:0];

  // Scan position
  logic [PW-1:0]         r_p;
  logic [DW-1:0]         r_d;

  // Word buffers
  logic [WW-1:0]         r_shown;
  logic [WW-1:0]         r_pending;
  logic                  r_pend_valid;

  // Registered pins
  logic [6:0]            r_out7;
  logic [NUM_DIGITS-1:0] r_en_out;
  logic                  r_frame_done;
  logic                  r_update_ack;

  // Combinational helpers
  logic                  w_p_last;
  logic                  w_d_last;
  logic                  w_wrap;
  logic [DW+1:0]         w_nib_base;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic                  w_lz_blank;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_en_digit;

  assign w_p_last = (r_p == c_p_last);
  assign w_d_last = (r_d == c_d_last);
  // The one edge that ends a frame: last clock of the last digit slot.
  assign w_wrap   = w_p_last && w_d_last;

  // Bit offset of the current digit's nibble inside the shown word.
  assign w_nib_base = {r_d, 2'b00};
  assign w_nib      = r_shown[w_nib_base +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (w_nib),
    .seg    (w_seg)
  );

  // Only the current digit's enable goes low.
  assign w_en_digit = ~(NUM_DIGITS'(1) << r_d);

  // Leading-zero suppression: blank digit d>0 when it and every higher
  // nibble are zero; digit 0 always shows so a zero word reads "0".
  if (BLANK_LZ != 0) begin : g_lz
    logic [WW-1:0] w_upper;
    assign w_upper    = r_shown >> w_nib_base;
    assign w_lz_blank = (r_d != '0) && (w_upper == '0);
  end else begin : g_no_lz
    assign w_lz_blank = 1'b0;
  end

  // Slot clock 0 is the anti-ghosting gap between digits.
  assign w_blank = (r_p == '0) || w_lz_blank;

  // Prescaler and digit index: advance digit at the end of each slot.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_p <= '0;
      r_d <= '0;
    end else if (w_p_last) begin
      r_p <= '0;
      r_d <= w_d_last ? '0 : r_d + 1'b1;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

  // Load into pending any time; promote pending to shown only at frame wrap.
  // A load on the wrap edge lands in pending after the old word is applied.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_shown      <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_wrap && r_pend_valid) begin
        r_shown      <= r_pending;
        r_pend_valid <= 1'b0;
      end
      if (bus.load) begin
        r_pending    <= bus.data_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // One-clock status pulses aligned with the wrap edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_frame_done <= 1'b0;
      r_update_ack <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_update_ack <= w_wrap && r_pend_valid;
    end
  end

  // Registered pin decode of the current scan state, glitch-free on the board.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_out7   <= SEG_BLANK;
      r_en_out <= c_en_off;
    end else if (w_blank) begin
      r_out7   <= SEG_BLANK;
      r_en_out <= c_en_off;
    end else begin
      r_out7   <= w_seg;
      r_en_out <= w_en_digit;
    end
  end

  assign bus.out7       = r_out7;
  assign bus.en_out     = r_en_out;
  assign bus.frame_done = r_frame_done;
  assign bus.update_ack = r_update_ack;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Brief    : Directed self-checking bench for seg7_scan_driver. Three
//             instances share clock and reset: A (8 digits, div 4, no LZ),
//             B (8 digits, div 4, LZ), C (4 digits, div 2, no LZ).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [6:0] C_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  // 32'h1234ABCD, digits 0..7: D,C,B,A,4,3,2,1
  localparam logic [6:0] C_WORD_SEGS [8] = '{
    7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79
  };

  always #5 Clk = ~Clk;

  seg7_scan_driver_if #(.NUM_DIGITS(8)) if_a ();
  seg7_scan_driver_if #(.NUM_DIGITS(8)) if_b ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_c ();

  seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_a (
    .Clk(Clk), .Rst(Rst), .bus(if_a));
  seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_b (
    .Clk(Clk), .Rst(Rst), .bus(if_b));
  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(2), .BLANK_LZ(0)) dut_c (
    .Clk(Clk), .Rst(Rst), .bus(if_c));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset state of all three instances; a load during reset must be ignored.
  task automatic test_reset();
    Rst = 1'b0;
    if_a.load = 1'b1; if_a.data_in = 32'hDEAD_BEEF;
    if_b.load = 1'b0; if_b.data_in = '0;
    if_c.load = 1'b0; if_c.data_in = '0;
    repeat (3) tick();
    if_a.load = 1'b0;
    n_tests++; if (if_a.en_out !== 8'hFF) begin n_fail++; $display("FAIL rst_en_a got %h exp FF", if_a.en_out); end
    n_tests++; if (if_a.out7 !== 7'h7F) begin n_fail++; $display("FAIL rst_out7_a got %h exp 7F", if_a.out7); end
    n_tests++; if (if_a.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd_a got %b exp 0", if_a.frame_done); end
    n_tests++; if (if_a.update_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_a got %b exp 0", if_a.update_ack); end
    n_tests++; if (if_b.en_out !== 8'hFF) begin n_fail++; $display("FAIL rst_en_b got %h exp FF", if_b.en_out); end
    n_tests++; if (if_c.en_out !== 4'hF) begin n_fail++; $display("FAIL rst_en_c got %h exp F", if_c.en_out); end
  endtask

  // Scan pattern from reset with shown=0; frame_done after 32 clocks.
  task automatic test_scan();
    int p, d;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    Rst = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      exp_en  = (p == 0) ? 8'hFF : ~(8'h01 << d);
      exp_seg = (p == 0) ? 7'h7F : 7'h40;
      n_tests++; if (if_a.en_out !== exp_en) begin n_fail++; $display("FAIL scan_en j=%0d got %h exp %h", j, if_a.en_out, exp_en); end
      n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL scan_out7 j=%0d got %h exp %h", j, if_a.out7, exp_seg); end
      n_tests++; if (if_a.frame_done !== (j == 32)) begin n_fail++; $display("FAIL scan_fd j=%0d got %b", j, if_a.frame_done); end
      n_tests++; if (if_a.update_ack !== 1'b0) begin n_fail++; $display("FAIL scan_ack j=%0d got %b exp 0", j, if_a.update_ack); end
    end
  endtask

  // Mid-frame load: nothing changes until wrap, then the whole word shows.
  task automatic test_load();
    int p, d;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    for (int j = 1; j <= 32; j++) begin
      if_a.load = (j == 6); if_a.data_in = 32'h1234_ABCD;
      tick();
      p = (j - 1) % 4;
      exp_seg = (p == 0) ? 7'h7F : 7'h40;
      n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL load_hold j=%0d got %h exp %h", j, if_a.out7, exp_seg); end
      n_tests++; if (if_a.update_ack !== (j == 32)) begin n_fail++; $display("FAIL load_ack j=%0d got %b", j, if_a.update_ack); end
      n_tests++; if (if_a.frame_done !== (j == 32)) begin n_fail++; $display("FAIL load_fd j=%0d got %b", j, if_a.frame_done); end
    end
    if_a.load = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      exp_en  = (p == 0) ? 8'hFF : ~(8'h01 << d);
      exp_seg = (p == 0) ? 7'h7F : C_WORD_SEGS[d];
      n_tests++; if (if_a.en_out !== exp_en) begin n_fail++; $display("FAIL word_en j=%0d got %h exp %h", j, if_a.en_out, exp_en); end
      n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL word_out7 j=%0d got %h exp %h", j, if_a.out7, exp_seg); end
      n_tests++; if (if_a.update_ack !== 1'b0) begin n_fail++; $display("FAIL word_ack j=%0d got %b exp 0", j, if_a.update_ack); end
    end
  endtask

  // Two loads in one frame: last wins; leading-zero blanking on instance B.
  task automatic test_two_loads();
    int p, d;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    for (int j = 1; j <= 32; j++) begin
      if_b.load    = (j == 3) || (j == 9);
      if_b.data_in = (j == 3) ? 32'h1111_1111 : 32'h0000_00F0;
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      exp_en  = (p == 0 || d != 0) ? 8'hFF : 8'hFE;
      exp_seg = (p == 0 || d != 0) ? 7'h7F : 7'h40;
      n_tests++; if (if_b.en_out !== exp_en) begin n_fail++; $display("FAIL lz0_en j=%0d got %h exp %h", j, if_b.en_out, exp_en); end
      n_tests++; if (if_b.out7 !== exp_seg) begin n_fail++; $display("FAIL lz0_out7 j=%0d got %h exp %h", j, if_b.out7, exp_seg); end
      n_tests++; if (if_b.update_ack !== (j == 32)) begin n_fail++; $display("FAIL two_ack j=%0d got %b", j, if_b.update_ack); end
    end
    if_b.load = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      if (p == 0 || d >= 2) begin exp_en = 8'hFF; exp_seg = 7'h7F; end
      else if (d == 0)      begin exp_en = 8'hFE; exp_seg = 7'h40; end
      else                  begin exp_en = 8'hFD; exp_seg = 7'h0E; end
      n_tests++; if (if_b.en_out !== exp_en) begin n_fail++; $display("FAIL lz_en j=%0d got %h exp %h", j, if_b.en_out, exp_en); end
      n_tests++; if (if_b.out7 !== exp_seg) begin n_fail++; $display("FAIL lz_out7 j=%0d got %h exp %h", j, if_b.out7, exp_seg); end
    end
  endtask

  // Load on the wrap edge with a word already pending.
  task automatic test_wrap_load();
    int p, d;
    logic [6:0] exp_seg;
    for (int j = 1; j <= 32; j++) begin
      if_a.load    = (j == 10) || (j == 32);
      if_a.data_in = (j == 10) ? 32'h0000_0005 : 32'h0000_0007;
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      exp_seg = (p == 0) ? 7'h7F : C_WORD_SEGS[d];
      n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL wl_old j=%0d got %h exp %h", j, if_a.out7, exp_seg); end
      n_tests++; if (if_a.update_ack !== (j == 32)) begin n_fail++; $display("FAIL wl_ack1 j=%0d got %b", j, if_a.update_ack); end
    end
    if_a.load = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 32; j++) begin
        tick();
        p = (j - 1) % 4; d = (j - 1) / 4;
        if (p == 0)      exp_seg = 7'h7F;
        else if (d != 0) exp_seg = 7'h40;
        else             exp_seg = (f == 0) ? 7'h12 : 7'h78;
        n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL wl_out7 f=%0d j=%0d got %h exp %h", f, j, if_a.out7, exp_seg); end
        n_tests++; if (if_a.update_ack !== (j == 32 && f == 0)) begin n_fail++; $display("FAIL wl_ack f=%0d j=%0d got %b", f, j, if_a.update_ack); end
      end
    end
  endtask

  // Reset during digit 5 with a pending word: pending is discarded.
  task automatic test_reset_mid();
    int p, d;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    for (int j = 1; j <= 22; j++) begin
      if_a.load = (j == 2); if_a.data_in = 32'h9999_9999;
      tick();
    end
    Rst = 1'b0;
    if_a.load = 1'b1; if_a.data_in = 32'hAAAA_AAAA;
    tick();
    if_a.load = 1'b0;
    n_tests++; if (if_a.en_out !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_en got %h exp FF", if_a.en_out); end
    n_tests++; if (if_a.out7 !== 7'h7F) begin n_fail++; $display("FAIL mid_rst_out7 got %h exp 7F", if_a.out7); end
    n_tests++; if (if_a.frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fd got %b exp 0", if_a.frame_done); end
    tick();
    Rst = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      tick();
      p = (j - 1) % 4; d = (j - 1) / 4;
      exp_en  = (p == 0) ? 8'hFF : ~(8'h01 << d);
      exp_seg = (p == 0) ? 7'h7F : 7'h40;
      n_tests++; if (if_a.en_out !== exp_en) begin n_fail++; $display("FAIL mid_en j=%0d got %h exp %h", j, if_a.en_out, exp_en); end
      n_tests++; if (if_a.out7 !== exp_seg) begin n_fail++; $display("FAIL mid_out7 j=%0d got %h exp %h", j, if_a.out7, exp_seg); end
      n_tests++; if (if_a.update_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack j=%0d got %b exp 0", j, if_a.update_ack); end
      n_tests++; if (if_a.frame_done !== (j == 32)) begin n_fail++; $display("FAIL mid_fd j=%0d got %b", j, if_a.frame_done); end
    end
  endtask

  // 4-digit / div-2 instance: sweep every hex value, one enable at a time.
  task automatic test_sweep();
    logic [15:0] words [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [15:0] w;
    logic [15:0] seen;
    logic [3:0]  nib;
    logic [3:0]  exp_en;
    logic [6:0]  exp_seg;
    int p, d;
    seen = '0;
    for (int f = 0; f <= 4; f++) begin
      for (int j = 1; j <= 8; j++) begin
        if_c.load    = (j == 1) && (f < 4);
        if_c.data_in = (f < 4) ? words[f] : 16'h0000;
        tick();
        p = (j - 1) % 2; d = (j - 1) / 2;
        w   = (f > 0) ? words[f - 1] : 16'h0000;
        nib = w[4*d +: 4];
        exp_en  = (p == 0) ? 4'hF : ~(4'h1 << d);
        exp_seg = (p == 0) ? 7'h7F : C_HEX[nib];
        n_tests++; if (if_c.en_out !== exp_en) begin n_fail++; $display("FAIL sw_en f=%0d j=%0d got %h exp %h", f, j, if_c.en_out, exp_en); end
        n_tests++; if (if_c.out7 !== exp_seg) begin n_fail++; $display("FAIL sw_out7 f=%0d j=%0d got %h exp %h", f, j, if_c.out7, exp_seg); end
        n_tests++; if ($countones(~if_c.en_out) > 1) begin n_fail++; $display("FAIL sw_onehot f=%0d j=%0d got %h exp <=1 low", f, j, if_c.en_out); end
        n_tests++; if (if_c.update_ack !== (j == 8 && f < 4)) begin n_fail++; $display("FAIL sw_ack f=%0d j=%0d got %b", f, j, if_c.update_ack); end
        n_tests++; if (if_c.frame_done !== (j == 8)) begin n_fail++; $display("FAIL sw_fd f=%0d j=%0d got %b", f, j, if_c.frame_done); end
        if (p == 1 && f > 0 && if_c.out7 === C_HEX[nib]) seen[nib] = 1'b1;
      end
    end
    if_c.load = 1'b0;
    n_tests++; if (seen !== 16'hFFFF) begin n_fail++; $display("FAIL sw_coverage got %h exp FFFF", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_two_loads();
    test_wrap_load();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
